// File: rtl/stream_unpacker_if.sv
// Handshake bundle between the wide-word streamer, the unpacker and the compute array.
// The slave modport is the unpacker's view; the master modport drives it.
interface stream_unpacker_if #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 32
);
  logic [IN_WIDTH-1:0]  dat_in;
  logic                 dat_in_vld;
  logic                 dat_in_done;
  logic [OUT_WIDTH-1:0] dat_out;
  logic                 dat_out_vld;
  logic                 dat_out_rdy;
  logic                 dat_out_last;
  logic                 done;
  logic                 overflow;

  modport master (
    output dat_in,
    output dat_in_vld,
    output dat_in_done,
    output dat_out_rdy,
    input  dat_out,
    input  dat_out_vld,
    input  dat_out_last,
    input  done,
    input  overflow
  );

  modport slave (
    input  dat_in,
    input  dat_in_vld,
    input  dat_in_done,
    input  dat_out_rdy,
    output dat_out,
    output dat_out_vld,
    output dat_out_last,
    output done,
    output overflow
  );
endinterface

// File: rtl/stream_unpacker.sv
// Buffers wide input words in a small FIFO and replays each one as R narrow lanes
// (LSB lane first) on a valid/ready stream, marking the final lane of each burst.
module stream_unpacker #(
  parameter int IN_WIDTH        = 256,
  parameter int OUT_WIDTH       = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int log2_FIFO_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_unpacker_if.slave bus
);
  localparam int R       = IN_WIDTH / OUT_WIDTH;
  localparam int LANE_W  = (R > 1) ? $clog2(R) : 1;
  localparam int ENTRY_W = IN_WIDTH + 1;
  localparam int CNT_W   = log2_FIFO_DEPTH + 1;

  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(R - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // FIFO storage: {last_flag, word}
  logic [ENTRY_W-1:0]         fifo_mem [FIFO_DEPTH];
  logic [log2_FIFO_DEPTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [log2_FIFO_DEPTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]           count_reg, count_next;
  logic                       overflow_reg, overflow_next;

  // Holding stage
  logic [IN_WIDTH-1:0] hold_word_reg, hold_word_next;
  logic                hold_last_reg, hold_last_next;
  logic [LANE_W-1:0]   lane_reg, lane_next;
  logic                hold_vld_reg, hold_vld_next;
  logic                done_reg, done_next;

  logic               fifo_empty;
  logic               fifo_full;
  logic               lane_final;
  logic               xfer;
  logic               final_xfer;
  logic               pop;
  logic               push;
  logic               drop;
  logic [ENTRY_W-1:0] rd_entry;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == FULL_COUNT);
  assign lane_final = (lane_reg == LAST_LANE);
  assign xfer       = hold_vld_reg & bus.dat_out_rdy;
  assign final_xfer = xfer & lane_final;

  // Refilling on the final-lane transfer keeps back-to-back words bubble-free.
  assign pop  = ~fifo_empty & (~hold_vld_reg | final_xfer);
  assign push = bus.dat_in_vld & (~fifo_full | pop);
  assign drop = bus.dat_in_vld & fifo_full & ~pop;

  assign rd_entry = fifo_mem[rd_ptr_reg];

  // Storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {bus.dat_in_done & bus.dat_in_vld, bus.dat_in};
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg | drop;

    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    hold_word_next = hold_word_reg;
    hold_last_next = hold_last_reg;
    lane_next      = lane_reg;
    hold_vld_next  = hold_vld_reg;
    done_next      = final_xfer & hold_last_reg;

    if (pop) begin
      hold_word_next = rd_entry[IN_WIDTH-1:0];
      hold_last_next = rd_entry[IN_WIDTH];
      lane_next      = '0;
      hold_vld_next  = 1'b1;
    end else if (xfer) begin
      if (lane_final) begin
        lane_next     = '0;
        hold_vld_next = 1'b0;
      end else begin
        lane_next = lane_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      hold_word_reg <= '0;
      hold_last_reg <= 1'b0;
      lane_reg      <= '0;
      hold_vld_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      hold_word_reg <= hold_word_next;
      hold_last_reg <= hold_last_next;
      lane_reg      <= lane_next;
      hold_vld_reg  <= hold_vld_next;
      done_reg      <= done_next;
    end
  end

  // Lane select straight from the holding register: no path from dat_in.
  logic [OUT_WIDTH-1:0] lanes [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_lane
    assign lanes[gi] = hold_word_reg[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  assign bus.dat_out      = lanes[lane_reg];
  assign bus.dat_out_vld  = hold_vld_reg;
  assign bus.dat_out_last = hold_vld_reg & hold_last_reg & lane_final;
  assign bus.done         = done_reg;
  assign bus.overflow     = overflow_reg;

  a_count_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    count_reg <= FULL_COUNT);

  a_overflow_sticky : assert property (@(posedge clk) disable iff (!rst_n)
    overflow_reg |=> overflow_reg);

  a_vld_holds : assert property (@(posedge clk) disable iff (!rst_n)
    (hold_vld_reg & ~bus.dat_out_rdy) |=> hold_vld_reg);

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: a per-cycle vector table for the single-word case,
// then scripted bursts whose lanes are scoreboarded against bench-generated words.
module tb_stream_unpacker;
  localparam int IN_W  = 256;
  localparam int OUT_W = 32;
  localparam int R     = IN_W / OUT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_unpacker_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  stream_unpacker #(
    .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .FIFO_DEPTH(8), .log2_FIFO_DEPTH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    logic        vld;
    logic        dn;
    logic        rdy;
    logic        exp_vld;
    logic        exp_last;
    logic        exp_done;
    logic [31:0] exp_dat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Monitor state (written only by the monitor)
  beat_t       got_q[$];
  int          done_cnt = 0;
  int          stab_viol = 0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;

  beat_t exp_q[$];
  logic  rdy_level = 1'b0;
  logic  rdy_toggle = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.dat_out_vld || bus.dat_out !== prev_dat)) begin
        stab_viol = stab_viol + 1;
      end
      if (bus.dat_out_vld && bus.dat_out_rdy) begin
        got_q.push_back('{d: bus.dat_out, last: bus.dat_out_last, cyc: cyc});
        $display("beat cyc=%0d dat=0x%08h last=%0b", cyc, bus.dat_out, bus.dat_out_last);
      end
      if (bus.done) begin
        done_cnt = done_cnt + 1;
        $display("done cyc=%0d", cyc);
      end
      prev_stall = bus.dat_out_vld && !bus.dat_out_rdy;
      prev_dat   = bus.dat_out;
    end
  end

  function automatic logic [31:0] lane_of(input int b, input int w, input int k);
    return (32'(b) << 24) | (32'(w) << 16) | 32'(k);
  endfunction

  function automatic logic [IN_W-1:0] word_of(input int b, input int w);
    logic [IN_W-1:0] x;
    x = '0;
    for (int k = 0; k < R; k++) x[k*OUT_W +: OUT_W] = lane_of(b, w, k);
    return x;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic dn, input logic [IN_W-1:0] w);
    @(posedge clk);
    #1;
    bus.dat_in_vld  = v;
    bus.dat_in_done = dn;
    bus.dat_in      = w;
    bus.dat_out_rdy = rdy_toggle ? ~bus.dat_out_rdy : rdy_level;
  endtask

  task automatic send_burst(input int b, input int n);
    for (int w = 0; w < n; w++) drive(1'b1, (w == n - 1), word_of(b, w));
  endtask

  task automatic expect_words(input int b, input int n, input logic with_last);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < R; k++)
        exp_q.push_back('{d: lane_of(b, w, k), last: with_last && (w == n - 1) && (k == R - 1), cyc: 0});
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (got_q.size() < target && k < budget) begin
      drive(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      k++;
    end
    chk({name, "_timeout"}, int'(got_q.size() >= target), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
  endtask

  task automatic compare_beats(input string name, input int base);
    chk({name, "_count"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      chk($sformatf("%s_dat[%0d]", name, i), int'(got_q[base+i].d), int'(exp_q[i].d));
      chk($sformatf("%s_last[%0d]", name, i), int'(got_q[base+i].last), int'(exp_q[i].last));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   base, dbase, sbase, gaps;

    for (int i = 0; i < 12; i++) begin
      vecs[i].vld      = (i == 0);
      vecs[i].dn       = (i == 0);
      vecs[i].rdy      = 1'b1;
      vecs[i].exp_vld  = (i >= 2 && i <= 9);
      vecs[i].exp_dat  = 32'(i - 2);
      vecs[i].exp_last = (i == 9);
      vecs[i].exp_done = (i == 10);
    end

    bus.dat_in      = '0;
    bus.dat_in_vld  = 1'b0;
    bus.dat_in_done = 1'b0;
    bus.dat_out_rdy = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", int'(bus.dat_out_vld), 0);
    chk("rst_dat", int'(bus.dat_out), 0);
    chk("rst_last", int'(bus.dat_out_last), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: single word, lane k = k, table-driven per cycle
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus.dat_in_vld  = vecs[i].vld;
      bus.dat_in_done = vecs[i].dn;
      bus.dat_in      = vecs[i].vld ? word_of(0, 0) : '0;
      bus.dat_out_rdy = vecs[i].rdy;
      @(negedge clk);
      #1;
      chk($sformatf("t1_vld[%0d]", i), int'(bus.dat_out_vld), int'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("t1_dat[%0d]", i), int'(bus.dat_out), int'(vecs[i].exp_dat));
      chk($sformatf("t1_last[%0d]", i), int'(bus.dat_out_last), int'(vecs[i].exp_last));
      chk($sformatf("t1_done[%0d]", i), int'(bus.done), int'(vecs[i].exp_done));
    end

    // T2: 8 back-to-back words, rdy high
    rdy_level = 1'b1;
    base = got_q.size(); dbase = done_cnt;
    exp_q.delete(); expect_words(2, 8, 1'b1);
    send_burst(2, 8);
    wait_beats("t2", base + 64, 200);
    idle(4);
    compare_beats("t2", base);
    gaps = 0;
    for (int i = base + 1; i < got_q.size() && i < base + 64; i++)
      if (got_q[i].cyc != got_q[i-1].cyc + 1) gaps++;
    chk("t2_gaps", gaps, 0);
    chk("t2_done", done_cnt - dbase, 1);
    chk("t2_ovf", int'(bus.overflow), 0);

    // T3: same burst, rdy toggling every cycle
    rdy_toggle = 1'b1;
    base = got_q.size(); dbase = done_cnt; sbase = stab_viol;
    exp_q.delete(); expect_words(3, 8, 1'b1);
    send_burst(3, 8);
    wait_beats("t3", base + 64, 400);
    idle(6);
    compare_beats("t3", base);
    chk("t3_done", done_cnt - dbase, 1);
    chk("t3_stable", stab_viol - sbase, 0);
    rdy_toggle = 1'b0;

    // T4: 10 words with rdy low, word 9 dropped
    rdy_level = 1'b0;
    idle(1);
    base = got_q.size(); dbase = done_cnt; sbase = stab_viol;
    send_burst(4, 10);
    @(negedge clk);
    #1;
    chk("t4_ovf_before", int'(bus.overflow), 0);
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("t4_ovf_after", int'(bus.overflow), 1);
    chk("t4_vld_held", int'(bus.dat_out_vld), 1);
    chk("t4_dat_held", int'(bus.dat_out), int'(lane_of(4, 0, 0)));
    idle(5);
    chk("t4_no_xfer", got_q.size() - base, 0);
    rdy_level = 1'b1;
    exp_q.delete(); expect_words(4, 9, 1'b0);
    wait_beats("t4", base + 72, 200);
    idle(6);
    compare_beats("t4", base);
    chk("t4_done", done_cnt - dbase, 0);
    chk("t4_ovf_sticky", int'(bus.overflow), 1);
    chk("t4_stable", stab_viol - sbase, 0);

    // T5: reset at lane 3 of word 2, then a fresh burst
    base = got_q.size();
    send_burst(8, 8);
    wait_beats("t5_pre", base + 20, 200);
    chk("t5_at_lane", int'(bus.dat_out), int'(lane_of(8, 2, 3)));
    dbase = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", int'(bus.dat_out_vld), 0);
    chk("t5_rst_dat", int'(bus.dat_out), 0);
    chk("t5_rst_last", int'(bus.dat_out_last), 0);
    chk("t5_rst_done", int'(bus.done), 0);
    chk("t5_rst_ovf", int'(bus.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);
    chk("t5_no_done", done_cnt - dbase, 0);
    chk("t5_idle_vld", int'(bus.dat_out_vld), 0);
    base = got_q.size(); dbase = done_cnt;
    exp_q.delete(); expect_words(5, 8, 1'b1);
    send_burst(5, 8);
    wait_beats("t5", base + 64, 200);
    idle(4);
    compare_beats("t5", base);
    chk("t5_done", done_cnt - dbase, 1);
    chk("t5_ovf", int'(bus.overflow), 0);

    // T6: two bursts separated by one idle cycle
    base = got_q.size(); dbase = done_cnt;
    exp_q.delete(); expect_words(6, 3, 1'b1); expect_words(7, 2, 1'b1);
    send_burst(6, 3);
    drive(1'b0, 1'b0, '0);
    send_burst(7, 2);
    wait_beats("t6", base + 40, 200);
    idle(4);
    compare_beats("t6", base);
    chk("t6_done", done_cnt - dbase, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
